// File: rtl/flash_cmd_responder.sv
// Byte-wide AMD 29F040-style command responder (unlock, autoselect, program, erase) over a backing memory port.
// Optional chip erase is compiled in when FLASH_CHIP_ERASE_EN is defined.
module flash_cmd_responder #(
   parameter logic [7:0] MANUF_ID  = 8'h01,
   parameter logic [7:0] DEVICE_ID = 8'hA4,
   parameter int         SECTOR_W  = 16,
   parameter int         CHIP_W    = 19
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [22:0] base_addr,
   input  logic [22:0] addr,
   input  logic [7:0]  data_to_flash,
   input  logic        we,
   input  logic        ce,
   output logic [7:0]  data_from_flash,
   output logic        data_valid,
   output logic [22:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   input  logic        mem_ack
);

`ifdef FLASH_CHIP_ERASE_EN
   localparam int CNT_W = (CHIP_W > SECTOR_W) ? CHIP_W : SECTOR_W;
`else
   // a sector never exceeds the chip
   localparam int CNT_W = (SECTOR_W < CHIP_W) ? SECTOR_W : CHIP_W;
`endif
   localparam logic [22:0] SECTOR_MASK = 23'((64'd1 << SECTOR_W) - 64'd1);

   typedef enum logic [3:0] {
      CMD_READ,
      CMD_UNL1,
      CMD_UNL2,
      CMD_AUTOSEL,
      CMD_PROG,
      CMD_ERS_SETUP,
      CMD_ERS_UNL1,
      CMD_ERS_UNL2,
      CMD_BUSY_PRG_RD,
      CMD_BUSY_PRG_WR,
      CMD_BUSY_ERS
   } cmd_state_t;

   typedef enum logic [1:0] {
      BUS_IDLE,
      BUS_MEM_RD,
      BUS_RESP,
      BUS_HOLD
   } bus_state_t;

   cmd_state_t        cmd_state_reg, cmd_state_next;
   bus_state_t        bus_state_reg, bus_state_next;
   logic [7:0]        dout_reg, dout_next;
   logic              data_valid_reg, data_valid_next;
   logic [22:0]       mem_addr_reg, mem_addr_next;
   logic              mem_rd_reg, mem_rd_next;
   logic              mem_wr_reg, mem_wr_next;
   logic [7:0]        mem_dout_reg, mem_dout_next;
   logic [7:0]        prog_data_reg, prog_data_next;
   logic              toggle_reg, toggle_next;
   logic [22:0]       ers_base_reg, ers_base_next;
   logic [CNT_W-1:0]  ers_cnt_reg, ers_cnt_next;
`ifdef FLASH_CHIP_ERASE_EN
   logic              ers_chip_reg, ers_chip_next;
`endif

   logic [22:0] phys_addr;
   logic [22:0] sector_base;
   logic        at_555;
   logic        at_2aa;
   logic        busy;
   logic        prg_busy;
   logic        ers_busy;
   logic        ers_last;
   logic [7:0]  status_byte;
   logic [7:0]  id_byte;

   assign phys_addr   = base_addr + addr;
   assign sector_base = base_addr + (addr & ~SECTOR_MASK);
   assign at_555      = (addr[10:0] == 11'h555);
   assign at_2aa      = (addr[10:0] == 11'h2AA);
   assign prg_busy    = (cmd_state_reg == CMD_BUSY_PRG_RD) || (cmd_state_reg == CMD_BUSY_PRG_WR);
   assign ers_busy    = (cmd_state_reg == CMD_BUSY_ERS);
   assign busy        = prg_busy || ers_busy;
   assign status_byte = {prg_busy & ~prog_data_reg[7], toggle_reg, 2'b00, ers_busy, 3'b000};

`ifdef FLASH_CHIP_ERASE_EN
   assign ers_last = ers_chip_reg ? (&ers_cnt_reg) : (&ers_cnt_reg[SECTOR_W-1:0]);
`else
   assign ers_last = &ers_cnt_reg;
`endif

   always_comb begin
      id_byte = 8'h00;
      case (addr[1:0])
         2'd0:    id_byte = MANUF_ID;
         2'd1:    id_byte = DEVICE_ID;
         default: id_byte = 8'h00;
      endcase
   end

   always_comb begin
      cmd_state_next  = cmd_state_reg;
      bus_state_next  = bus_state_reg;
      dout_next       = dout_reg;
      data_valid_next = 1'b0;
      mem_addr_next   = mem_addr_reg;
      mem_rd_next     = mem_rd_reg;
      mem_wr_next     = mem_wr_reg;
      mem_dout_next   = mem_dout_reg;
      prog_data_next  = prog_data_reg;
      toggle_next     = toggle_reg;
      ers_base_next   = ers_base_reg;
      ers_cnt_next    = ers_cnt_reg;
`ifdef FLASH_CHIP_ERASE_EN
      ers_chip_next   = ers_chip_reg;
`endif

      // Embedded program/erase engine; owns the memory port only while busy.
      case (cmd_state_reg)
         CMD_BUSY_PRG_RD: begin
            if (mem_ack) begin
               mem_rd_next    = 1'b0;
               mem_wr_next    = 1'b1;
               mem_dout_next  = mem_din & prog_data_reg;
               cmd_state_next = CMD_BUSY_PRG_WR;
            end
         end
         CMD_BUSY_PRG_WR: begin
            if (mem_ack) begin
               mem_wr_next    = 1'b0;
               cmd_state_next = CMD_READ;
            end
         end
         CMD_BUSY_ERS: begin
            if (!mem_wr_reg) begin
               mem_wr_next   = 1'b1;
               mem_addr_next = ers_base_reg + 23'(ers_cnt_reg);
            end else if (mem_ack) begin
               mem_wr_next = 1'b0;
               if (ers_last) begin
                  cmd_state_next = CMD_READ;
               end else begin
                  ers_cnt_next = ers_cnt_reg + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase

      case (bus_state_reg)
         BUS_IDLE: begin
            if (ce) begin
               bus_state_next  = BUS_RESP;
               data_valid_next = 1'b1;
               if (we) begin
                  if (!busy) begin
                     if (data_to_flash == 8'hF0) begin
                        cmd_state_next = CMD_READ;
                     end else begin
                        case (cmd_state_reg)
                           CMD_READ: begin
                              if (at_555 && data_to_flash == 8'hAA) cmd_state_next = CMD_UNL1;
                           end
                           CMD_UNL1: begin
                              cmd_state_next = (at_2aa && data_to_flash == 8'h55) ? CMD_UNL2 : CMD_READ;
                           end
                           CMD_UNL2: begin
                              cmd_state_next = CMD_READ;
                              if (at_555) begin
                                 case (data_to_flash)
                                    8'h90:   cmd_state_next = CMD_AUTOSEL;
                                    8'hA0:   cmd_state_next = CMD_PROG;
                                    8'h80:   cmd_state_next = CMD_ERS_SETUP;
                                    default: cmd_state_next = CMD_READ;
                                 endcase
                              end
                           end
                           CMD_PROG: begin
                              prog_data_next = data_to_flash;
                              mem_addr_next  = phys_addr;
                              mem_rd_next    = 1'b1;
                              toggle_next    = 1'b0;
                              cmd_state_next = CMD_BUSY_PRG_RD;
                           end
                           CMD_ERS_SETUP: begin
                              cmd_state_next = (at_555 && data_to_flash == 8'hAA) ? CMD_ERS_UNL1 : CMD_READ;
                           end
                           CMD_ERS_UNL1: begin
                              cmd_state_next = (at_2aa && data_to_flash == 8'h55) ? CMD_ERS_UNL2 : CMD_READ;
                           end
                           CMD_ERS_UNL2: begin
                              cmd_state_next = CMD_READ;
                              if (data_to_flash == 8'h30) begin
                                 ers_base_next  = sector_base;
                                 ers_cnt_next   = '0;
                                 mem_dout_next  = 8'hFF;
                                 toggle_next    = 1'b0;
                                 cmd_state_next = CMD_BUSY_ERS;
`ifdef FLASH_CHIP_ERASE_EN
                                 ers_chip_next  = 1'b0;
                              end else if (data_to_flash == 8'h10 && at_555) begin
                                 ers_base_next  = base_addr;
                                 ers_cnt_next   = '0;
                                 mem_dout_next  = 8'hFF;
                                 toggle_next    = 1'b0;
                                 cmd_state_next = CMD_BUSY_ERS;
                                 ers_chip_next  = 1'b1;
`endif
                              end
                           end
                           default: ;
                        endcase
                     end
                  end
               end else if (busy) begin
                  dout_next   = status_byte;
                  toggle_next = ~toggle_reg;
               end else if (cmd_state_reg == CMD_AUTOSEL) begin
                  dout_next = id_byte;
               end else begin
                  bus_state_next  = BUS_MEM_RD;
                  data_valid_next = 1'b0;
                  mem_rd_next     = 1'b1;
                  mem_addr_next   = phys_addr;
               end
            end
         end
         BUS_MEM_RD: begin
            if (mem_ack) begin
               mem_rd_next     = 1'b0;
               dout_next       = mem_din;
               data_valid_next = 1'b1;
               bus_state_next  = BUS_RESP;
            end
         end
         // ce is still up while the requester reacts to data_valid
         BUS_RESP: bus_state_next = BUS_HOLD;
         default:  bus_state_next = BUS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_state_reg  <= CMD_READ;
         bus_state_reg  <= BUS_IDLE;
         dout_reg       <= 8'h00;
         data_valid_reg <= 1'b0;
         mem_addr_reg   <= '0;
         mem_rd_reg     <= 1'b0;
         mem_wr_reg     <= 1'b0;
         mem_dout_reg   <= 8'h00;
         prog_data_reg  <= 8'h00;
         toggle_reg     <= 1'b0;
         ers_base_reg   <= '0;
         ers_cnt_reg    <= '0;
`ifdef FLASH_CHIP_ERASE_EN
         ers_chip_reg   <= 1'b0;
`endif
      end else begin
         cmd_state_reg  <= cmd_state_next;
         bus_state_reg  <= bus_state_next;
         dout_reg       <= dout_next;
         data_valid_reg <= data_valid_next;
         mem_addr_reg   <= mem_addr_next;
         mem_rd_reg     <= mem_rd_next;
         mem_wr_reg     <= mem_wr_next;
         mem_dout_reg   <= mem_dout_next;
         prog_data_reg  <= prog_data_next;
         toggle_reg     <= toggle_next;
         ers_base_reg   <= ers_base_next;
         ers_cnt_reg    <= ers_cnt_next;
`ifdef FLASH_CHIP_ERASE_EN
         ers_chip_reg   <= ers_chip_next;
`endif
      end
   end

   assign data_from_flash = dout_reg;
   assign data_valid      = data_valid_reg;
   assign mem_addr        = mem_addr_reg;
   assign mem_rd          = mem_rd_reg;
   assign mem_wr          = mem_wr_reg;
   assign mem_dout        = mem_dout_reg;

endmodule

// File: tb/tb_flash_cmd_responder.sv
// Scoreboard bench for flash_cmd_responder: host responses and backing-memory traffic are checked against queues.
`timescale 1ns/1ps
module tb_flash_cmd_responder;
   localparam int          SW   = 8;
   localparam int          CW   = 10;
   localparam logic [22:0] BASE = 23'h010000;

   logic        clk;
   logic        reset_n;
   logic [22:0] base_addr;
   logic [22:0] addr;
   logic [7:0]  data_to_flash;
   logic        we;
   logic        ce;
   logic [7:0]  data_from_flash;
   logic        data_valid;
   logic [22:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        mem_ack;

   flash_cmd_responder #(
      .MANUF_ID (8'h01),
      .DEVICE_ID(8'hA4),
      .SECTOR_W (SW),
      .CHIP_W   (CW)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .base_addr      (base_addr),
      .addr           (addr),
      .data_to_flash  (data_to_flash),
      .we             (we),
      .ce             (ce),
      .data_from_flash(data_from_flash),
      .data_valid     (data_valid),
      .mem_addr       (mem_addr),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .mem_ack        (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_rd;
      logic [22:0] a;
      logic [7:0]  d;
   } rsp_t;

   typedef struct {
      logic [22:0] a;
      logic [7:0]  d;
   } mwr_t;

   rsp_t        exp_rsp_q[$];
   logic [22:0] exp_mrd_q[$];
   mwr_t        exp_mwr_q[$];
   logic [7:0]  mem[int];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          mem_lat = 0;
   int          both_high = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_get(input logic [22:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
   endfunction

   task automatic push_wr(input logic [22:0] a, input logic [7:0] d);
      mwr_t e;
      e.a = a;
      e.d = d;
      exp_mwr_q.push_back(e);
   endtask

   task automatic push_rsp(input logic is_rd, input logic [22:0] a, input logic [7:0] d);
      rsp_t e;
      e.is_rd = is_rd;
      e.a     = a;
      e.d     = d;
      exp_rsp_q.push_back(e);
   endtask

   // Backing memory: acks after mem_lat idle cycles, checks every access against the expected queues.
   initial begin
      int cnt;
      cnt     = 0;
      mem_ack = 1'b0;
      mem_din = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_rd && mem_wr) both_high++;
         if (!reset_n) begin
            mem_ack = 1'b0;
            cnt     = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            cnt     = 0;
         end else if (mem_rd || mem_wr) begin
            if (cnt >= mem_lat) begin
               cnt     = 0;
               mem_ack = 1'b1;
               if (mem_rd) begin
                  mem_din = mem_get(mem_addr);
                  if (exp_mrd_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL mem_rd_unexpected: got addr %h required none", mem_addr);
                  end else begin
                     chk("mem_rd_addr", 32'(mem_addr), 32'(exp_mrd_q.pop_front()));
                  end
               end else begin
                  mem[int'(mem_addr)] = mem_dout;
                  if (exp_mwr_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL mem_wr_unexpected: got addr %h data %h required none", mem_addr, mem_dout);
                  end else begin
                     mwr_t e;
                     e = exp_mwr_q.pop_front();
                     chk("mem_wr_addr", 32'(mem_addr), 32'(e.a));
                     chk("mem_wr_data", 32'(mem_dout), 32'(e.d));
                  end
               end
            end else begin
               cnt++;
            end
         end
      end
   end

   // Response monitor: every data_valid pulse consumes one expected response.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (reset_n && data_valid) begin
            if (exp_rsp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rsp_unexpected: got data_valid with %h required none", data_from_flash);
            end else begin
               e = exp_rsp_q.pop_front();
               if (e.is_rd) chk($sformatf("rd_data@%h", e.a), 32'(data_from_flash), 32'(e.d));
            end
         end
      end
   end

   task automatic host_acc(input logic w, input logic [22:0] a, input logic [7:0] d, output int lat);
      @(negedge clk);
      addr          = a;
      data_to_flash = d;
      we            = w;
      ce            = 1'b1;
      lat           = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!data_valid && lat < 500);
      if (!data_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL handshake_timeout: got no data_valid at addr %h required one", a);
      end
      $display("%s addr=%h wdata=%h rdata=%h lat=%0d", w ? "wr" : "rd", a, d, data_from_flash, lat);
      @(posedge clk);
      #1;
      ce = 1'b0;
      we = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [22:0] a, input logic [7:0] d);
      int lat;
      push_rsp(1'b0, a, 8'h00);
      host_acc(1'b1, a, d, lat);
      chk("wr_latency", 32'(lat), 32'd1);
   endtask

   task automatic rd_reg(input logic [22:0] a, input logic [7:0] exp);
      int lat;
      push_rsp(1'b1, a, exp);
      host_acc(1'b0, a, 8'h00, lat);
      chk("reg_rd_latency", 32'(lat), 32'd1);
   endtask

   task automatic rd_mem(input logic [22:0] a, input logic [7:0] exp);
      int lat;
      exp_mrd_q.push_back(BASE + a);
      push_rsp(1'b1, a, exp);
      host_acc(1'b0, a, 8'h00, lat);
      if (mem_lat == 0) chk("mem_rd_latency", 32'(lat), 32'd2);
   endtask

   task automatic unlock();
      wr(23'h000555, 8'hAA);
      wr(23'h0002AA, 8'h55);
   endtask

   task automatic erase_prefix();
      unlock();
      wr(23'h000555, 8'h80);
      unlock();
   endtask

   task automatic drain(input int max_cyc);
      int n;
      n = 0;
      while ((exp_mwr_q.size() != 0 || mem_wr || mem_rd) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending_writes", 32'(exp_mwr_q.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n       = 1'b0;
      base_addr     = BASE;
      addr          = '0;
      data_to_flash = 8'h00;
      we            = 1'b0;
      ce            = 1'b0;
      mem[int'(BASE + 23'h000123)] = 8'h5A;
      mem[int'(BASE + 23'h000100)] = 8'h3C;
      mem[int'(BASE + 23'h000000)] = 8'h99;
      mem[int'(BASE + 23'h000300)] = 8'h77;

      repeat (3) @(negedge clk);
      chk("rst_data_from_flash", 32'(data_from_flash), 32'd0);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_dout", 32'(mem_dout), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // plain memory read through base_addr
      mem_lat = 0;
      rd_mem(23'h000123, 8'h5A);

      // autoselect, then reset back to array reads
      unlock();
      wr(23'h000555, 8'h90);
      rd_reg(23'h000000, 8'h01);
      rd_reg(23'h000001, 8'hA4);
      rd_reg(23'h000002, 8'h00);
      rd_reg(23'h000003, 8'h00);
      wr(23'h000000, 8'hF0);
      rd_mem(23'h000000, 8'h99);

      // program 0x0F over 0x3C -> 0x0C; status polled while busy
      mem_lat = 20;
      unlock();
      wr(23'h000555, 8'hA0);
      exp_mrd_q.push_back(BASE + 23'h000100);
      push_wr(BASE + 23'h000100, 8'h0C);
      wr(23'h000100, 8'h0F);
      rd_reg(23'h000100, 8'h80);
      rd_reg(23'h000100, 8'hC0);
      drain(2000);
      mem_lat = 0;
      rd_mem(23'h000100, 8'h0C);

      // sector erase of the sector at 0x20000
      erase_prefix();
      for (int i = 0; i < (1 << SW); i++) push_wr(BASE + 23'h020000 + 23'(i), 8'hFF);
      wr(23'h020000, 8'h30);
      rd_reg(23'h020000, 8'h08);
      drain(5000);
      rd_mem(23'h020010, 8'hFF);
      rd_mem(23'h0200FF, 8'hFF);
      rd_mem(23'h020100, 8'h00);

      // broken unlock: following A0 and data write must not program
      wr(23'h000555, 8'hAA);
      wr(23'h000123, 8'h55);
      wr(23'h000555, 8'hA0);
      wr(23'h000300, 8'h12);
      repeat (10) @(negedge clk);
      rd_mem(23'h000300, 8'h77);

      // reset in the middle of a sector erase
      mem_lat = 2;
      erase_prefix();
      for (int i = 0; i < (1 << SW); i++) push_wr(BASE + 23'h030000 + 23'(i), 8'hFF);
      wr(23'h030000, 8'h30);
      repeat (40) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
      chk("midrst_mem_rd", 32'(mem_rd), 32'd0);
      chk("midrst_data_valid", 32'(data_valid), 32'd0);
      exp_mwr_q.delete();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd_mem(23'h000100, 8'h0C);
      mem_lat = 0;
      repeat (20) @(negedge clk);

      // chip erase command
      erase_prefix();
`ifdef FLASH_CHIP_ERASE_EN
      for (int i = 0; i < (1 << CW); i++) push_wr(BASE + 23'(i), 8'hFF);
      wr(23'h000555, 8'h10);
      rd_reg(23'h000000, 8'h08);
      drain(10000);
      rd_mem(23'h000300, 8'hFF);
`else
      wr(23'h000555, 8'h10);
      repeat (20) @(negedge clk);
      rd_mem(23'h000300, 8'h77);
`endif

      repeat (5) @(negedge clk);
      chk("left_rsp", 32'(exp_rsp_q.size()), 32'd0);
      chk("left_mem_rd", 32'(exp_mrd_q.size()), 32'd0);
      chk("left_mem_wr", 32'(exp_mwr_q.size()), 32'd0);
      chk("rd_wr_overlap", 32'(both_high), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
